// File: rtl/rec_seq_ctrl.sv
// rtl/rec_seq_ctrl.sv - phase/duty/reset sequencer for the rectangular-wave generator
module rec_seq_ctrl #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic [7:0]       cfg_duty,
  input  logic [CNT_W-1:0] cfg_cycles,
  input  logic             start,
  input  logic             stop,
  output logic [7:0]       phase_out,
  output logic [7:0]       duty_out,
  output logic             gen_rst,
  output logic             busy,
  output logic             wrap_pulse,
  output logic             done_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [7:0]       duty_q, duty_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [ACC_W-1:0] sh_inc_q, sh_inc_d;
  logic [7:0]       sh_duty_q, sh_duty_d;
  logic [CNT_W-1:0] sh_cycles_q, sh_cycles_d;
  logic             pending_q, pending_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic             done_pulse_q, done_pulse_d;
  logic             gen_rst_q, gen_rst_d;
  logic             busy_q, busy_d;
  logic             cfg_ready_q, cfg_ready_d;

  logic [ACC_W:0]   sum;
  logic [CNT_W-1:0] cnt_inc;
  logic             running;
  logic             wrap;
  logic             xfer;
  logic             burst_end;
  logic             go_idle;

  assign phase_out  = acc_q[ACC_W-1 -: 8];
  assign duty_out   = duty_q;
  assign gen_rst    = gen_rst_q;
  assign busy       = busy_q;
  assign wrap_pulse = wrap_pulse_q;
  assign done_pulse = done_pulse_q;
  assign cfg_ready  = cfg_ready_q;

  // Datapath helpers: accumulator carry, saturating period count, burst-end detect.
  always_comb begin
    running   = (state_q != ST_IDLE);
    sum       = {1'b0, acc_q} + {1'b0, inc_q};
    wrap      = running && sum[ACC_W];
    xfer      = cfg_valid && cfg_ready_q;
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    // cycles_q is the value before any shadow copy on this same wrap.
    burst_end = (state_q == ST_RUN) && wrap && (cycles_q != '0) && (cnt_inc == cycles_q);
  end

  // Next-state, config capture and registered-output computation.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    inc_d        = inc_q;
    duty_d       = duty_q;
    cycles_d     = cycles_q;
    sh_inc_d     = sh_inc_q;
    sh_duty_d    = sh_duty_q;
    sh_cycles_d  = sh_cycles_q;
    pending_d    = pending_q;
    wrap_pulse_d = 1'b0;
    done_pulse_d = 1'b0;
    go_idle      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        acc_d = '0;
        // A shadow word captured on the edge that ended a run is applied
        // here so the port never stays blocked while idle.
        if (pending_q) begin
          inc_d     = sh_inc_q;
          duty_d    = sh_duty_q;
          cycles_d  = sh_cycles_q;
          pending_d = 1'b0;
        end
        if (xfer) begin
          inc_d    = cfg_inc;
          duty_d   = cfg_duty;
          cycles_d = cfg_cycles;
        end
        if (start && !stop) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        acc_d = sum[ACC_W-1:0];
        if (wrap) begin
          wrap_pulse_d = 1'b1;
          cnt_d        = cnt_inc;
          if (pending_q) begin
            inc_d     = sh_inc_q;
            duty_d    = sh_duty_q;
            cycles_d  = sh_cycles_q;
            pending_d = 1'b0;
          end
        end
        // xfer implies !pending_q, so this never collides with the copy above.
        if (xfer) begin
          sh_inc_d    = cfg_inc;
          sh_duty_d   = cfg_duty;
          sh_cycles_d = cfg_cycles;
          pending_d   = 1'b1;
        end
        if (state_q == ST_RUN) begin
          if (burst_end) begin
            go_idle = 1'b1;
          end else if (stop) begin
            // With a zero increment no wrap would ever come, so stop at once.
            if (inc_q == '0) begin
              go_idle = 1'b1;
            end else begin
              state_d = ST_STOPPING;
            end
          end
        end else if (wrap || (inc_q == '0)) begin
          go_idle = 1'b1;
        end
      end
    endcase

    if (go_idle) begin
      state_d      = ST_IDLE;
      acc_d        = '0;
      done_pulse_d = 1'b1;
    end

    gen_rst_d   = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    cfg_ready_d = !pending_d;
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      inc_q        <= '0;
      duty_q       <= '0;
      cycles_q     <= '0;
      sh_inc_q     <= '0;
      sh_duty_q    <= '0;
      sh_cycles_q  <= '0;
      pending_q    <= 1'b0;
      wrap_pulse_q <= 1'b0;
      done_pulse_q <= 1'b0;
      gen_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      cfg_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      inc_q        <= inc_d;
      duty_q       <= duty_d;
      cycles_q     <= cycles_d;
      sh_inc_q     <= sh_inc_d;
      sh_duty_q    <= sh_duty_d;
      sh_cycles_q  <= sh_cycles_d;
      pending_q    <= pending_d;
      wrap_pulse_q <= wrap_pulse_d;
      done_pulse_q <= done_pulse_d;
      gen_rst_q    <= gen_rst_d;
      busy_q       <= busy_d;
      cfg_ready_q  <= cfg_ready_d;
    end
  end

endmodule

// File: doc/rec_seq_ctrl.md
Name: rec_seq_ctrl

Overview:
- Sequencer for the rectangular-wave generator: owns a phase accumulator and drives the generator's phase, duty-cycle and reset inputs.
- Accepts configuration (phase increment, duty, burst length) over a valid/ready handshake and supports start/stop.
- Mid-run configuration changes are applied glitch-free at a period boundary.
- Sits between the register/config interface and the generator instance.

Parameters:
- ACC_W, 16, phase accumulator width; phase output is the top 8 bits.
- CNT_W, 16, width of burst length and period counter.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  reset; synchronous, active-high.
- cfg_valid  input  1  configuration word valid.
- cfg_ready  output  1  block can accept configuration.
- cfg_inc  input  ACC_W  phase increment per clock.
- cfg_duty  input  8  duty threshold (0-255).
- cfg_cycles  input  CNT_W  periods per burst; 0 = continuous.
- start  input  1  start request, single-cycle pulse.
- stop  input  1  stop request, single-cycle pulse.
- phase_out  output  8  phase to generator (acc[ACC_W-1:ACC_W-8]).
- duty_out  output  8  active duty threshold to generator.
- gen_rst  output  1  generator reset, high when not running.
- busy  output  1  high in RUN or STOPPING.
- wrap_pulse  output  1  one-cycle pulse on each accumulator wrap.
- done_pulse  output  1  one-cycle pulse on every return to IDLE from RUN or STOPPING.

Behaviour:
- Reset values:
  - Outputs: phase_out=0, duty_out=0, gen_rst=1, busy=0, wrap_pulse=0, done_pulse=0, cfg_ready=1.
  - Internal: state=IDLE, acc=0, period count=0; active inc/duty/cycles=0; shadow regs=0; pending=0.
  - A reset during any state discards any pending shadow update.
- States: IDLE, RUN, STOPPING. All outputs are registered.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready at a clock edge.
  - cfg_ready = !pending.
  - In IDLE, a transfer writes the active inc/duty/cycles directly; duty_out updates on the next cycle.
  - In RUN/STOPPING, a transfer writes the shadow regs and sets pending=1.
- Accumulator: in RUN/STOPPING, acc <= acc + active_inc every cycle, modulo 2^ACC_W. A carry out is a wrap.
- On a wrap:
  - wrap_pulse=1 the next cycle; period count increments.
  - If pending: shadow is copied to active and pending cleared. The new duty_out/inc take effect from the following cycle.
  - The burst-end check uses cycles as it stood before this copy.
- IDLE -> RUN: on start (stop not also asserted). Next cycle: acc=0, period count=0, gen_rst=0, busy=1, phase_out=0. First increment is visible the cycle after.
- RUN -> IDLE: on a wrap where active cycles != 0 and the new period count == cycles.
- RUN -> STOPPING: on stop.
- STOPPING -> IDLE: on the next wrap; immediately if active_inc == 0.
- Entry to IDLE, next cycle: gen_rst=1, busy=0, acc=0, phase_out=0, done_pulse=1. duty_out is held.
- Ignored inputs: start in RUN/STOPPING; stop in IDLE; start and stop together in IDLE (stop wins, stays IDLE).
- Burst end and stop in the same cycle: burst end wins, go to IDLE.
- cfg_inc=0 in RUN holds the phase constant. There is no wrap, so a pending update stays pending until a stop.
- Period counter saturates at all-ones in continuous mode and never terminates.

Test Plan:
- Basic run: cfg inc=0x1000, duty=0x80, cycles=0 in IDLE, then start → gen_rst falls 1 cycle after start. phase_out steps 0x00,0x10,...,0xF0,0x00, and wrap_pulse fires every 16 cycles.
- Burst: inc=0x4000, cycles=3, start → exactly 3 wrap_pulses. done_pulse and gen_rst=1 on the cycle after the 3rd wrap, busy=0, phase_out=0.
- Mid-run update: running inc=0x1000 duty=0x40; send duty=0xC0 inc=0x2000 → cfg_ready=0 until the next wrap. duty_out stays 0x40 until the cycle after the wrap, then becomes 0xC0 and phase steps by 0x20.
- Stop: stop at phase 0x50 with inc=0x1000 → busy stays 1 and phase continues to the wrap. Then IDLE with done_pulse, exactly one more wrap_pulse.
- Corner cases:
  - start+stop together in IDLE → stays IDLE, no done_pulse.
  - stop with inc=0 → IDLE next cycle.
  - Second start during RUN → ignored; phase sequence unaffected.
- Reset mid-run with a pending update → all outputs at reset values the next cycle, cfg_ready=1. A later start uses the pre-reset active values cleared to 0 (duty_out=0).
